// File: rtl/chess_pkg.sv
// Shared chess move-generation types: direction codes, move word widths,
// colour-bit positions and the collector state encoding.
package chess_pkg;

  localparam int unsigned MOVE_W  = 11;
  localparam int unsigned KMOVE_W = 8;

  localparam int unsigned SLIDE_COLOR_BIT  = 10;
  localparam int unsigned KNIGHT_COLOR_BIT = 7;

  localparam logic [MOVE_W-1:0]  EMPTY_MOVE        = '0;
  localparam logic [KMOVE_W-1:0] EMPTY_KNIGHT_MOVE = '0;

  localparam int unsigned NUM_DIRS = 16;
  localparam int unsigned DIR_W    = 4;
  localparam int unsigned DST_W    = 6;
  localparam int unsigned CNT_W    = 5;

  // Sliding/king directions occupy codes 0-7, knight jumps 8-15.
  localparam logic [DIR_W-1:0] DIR_U   = 4'd0;
  localparam logic [DIR_W-1:0] DIR_D   = 4'd1;
  localparam logic [DIR_W-1:0] DIR_L   = 4'd2;
  localparam logic [DIR_W-1:0] DIR_R   = 4'd3;
  localparam logic [DIR_W-1:0] DIR_UL  = 4'd4;
  localparam logic [DIR_W-1:0] DIR_UR  = 4'd5;
  localparam logic [DIR_W-1:0] DIR_DL  = 4'd6;
  localparam logic [DIR_W-1:0] DIR_DR  = 4'd7;
  localparam logic [DIR_W-1:0] DIR_UUL = 4'd8;
  localparam logic [DIR_W-1:0] DIR_UUR = 4'd9;
  localparam logic [DIR_W-1:0] DIR_LLU = 4'd10;
  localparam logic [DIR_W-1:0] DIR_RRU = 4'd11;
  localparam logic [DIR_W-1:0] DIR_DDL = 4'd12;
  localparam logic [DIR_W-1:0] DIR_DDR = 4'd13;
  localparam logic [DIR_W-1:0] DIR_LLD = 4'd14;
  localparam logic [DIR_W-1:0] DIR_RRD = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } collect_state_e;

endpackage

// File: rtl/lowest_set_16.sv
// Combinational priority encoder: index of the lowest set bit and an any flag.
module lowest_set_16 (
  input  logic [15:0] req_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Scan from the top so the lowest set bit is written last and wins.
  always_comb begin
    idx_o = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req_i[i]) idx_o = 4'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/move_collector.sv
// Snapshots the 16 moves arriving at one square and streams the side-to-move's
// moves out over a valid/ready handshake, lowest direction code first.
module move_collector #(
  parameter int unsigned MOVE_W  = chess_pkg::MOVE_W,
  parameter int unsigned KMOVE_W = chess_pkg::KMOVE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               engineColor,
  input  logic [5:0]         posReg,
  input  logic [MOVE_W-1:0]  U_move,
  input  logic [MOVE_W-1:0]  D_move,
  input  logic [MOVE_W-1:0]  L_move,
  input  logic [MOVE_W-1:0]  R_move,
  input  logic [MOVE_W-1:0]  UL_move,
  input  logic [MOVE_W-1:0]  UR_move,
  input  logic [MOVE_W-1:0]  DL_move,
  input  logic [MOVE_W-1:0]  DR_move,
  input  logic [KMOVE_W-1:0] UUL_move,
  input  logic [KMOVE_W-1:0] UUR_move,
  input  logic [KMOVE_W-1:0] LLU_move,
  input  logic [KMOVE_W-1:0] RRU_move,
  input  logic [KMOVE_W-1:0] DDL_move,
  input  logic [KMOVE_W-1:0] DDR_move,
  input  logic [KMOVE_W-1:0] LLD_move,
  input  logic [KMOVE_W-1:0] RRD_move,
  input  logic               start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_dir,
  output logic [5:0]         out_dst,
  output logic [MOVE_W-1:0]  out_move,
  output logic               busy,
  output logic               done,
  output logic [4:0]         move_count
);

  import chess_pkg::*;

  collect_state_e                  state_q, state_d;
  logic [NUM_DIRS-1:0][MOVE_W-1:0] words_q, words_d, words_in;
  logic [NUM_DIRS-1:0]             mask_q, mask_d, mask_in;
  logic [DST_W-1:0]                dst_q, dst_d;
  logic [CNT_W-1:0]                count_q, count_d;
  logic                            valid_q, valid_d;
  logic [DIR_W-1:0]                dir_q, dir_d;
  logic [MOVE_W-1:0]               move_q, move_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic [DIR_W-1:0]                idx_d;
  logic                            any_d;
  logic                            handshake;

  // Gather live inputs by direction code; knight words are zero-extended.
  always_comb begin
    words_in          = '0;
    words_in[DIR_U]   = U_move;
    words_in[DIR_D]   = D_move;
    words_in[DIR_L]   = L_move;
    words_in[DIR_R]   = R_move;
    words_in[DIR_UL]  = UL_move;
    words_in[DIR_UR]  = UR_move;
    words_in[DIR_DL]  = DL_move;
    words_in[DIR_DR]  = DR_move;
    words_in[DIR_UUL] = MOVE_W'(UUL_move);
    words_in[DIR_UUR] = MOVE_W'(UUR_move);
    words_in[DIR_LLU] = MOVE_W'(LLU_move);
    words_in[DIR_RRU] = MOVE_W'(RRU_move);
    words_in[DIR_DDL] = MOVE_W'(DDL_move);
    words_in[DIR_DDR] = MOVE_W'(DDR_move);
    words_in[DIR_LLD] = MOVE_W'(LLD_move);
    words_in[DIR_RRD] = MOVE_W'(RRD_move);
  end

  // A word is pending when present and owned by the side to move.
  always_comb begin
    mask_in = '0;
    for (int i = 0; i < int'(NUM_DIRS); i++) begin
      if (i < int'(DIR_UUL)) begin
        mask_in[i] = (words_in[i] != MOVE_W'(EMPTY_MOVE)) &&
                     (words_in[i][SLIDE_COLOR_BIT] == engineColor);
      end else begin
        mask_in[i] = (words_in[i][KMOVE_W-1:0] != KMOVE_W'(EMPTY_KNIGHT_MOVE)) &&
                     (words_in[i][KNIGHT_COLOR_BIT] == engineColor);
      end
    end
  end

  assign handshake = valid_q && out_ready;

  // Next-state logic; outputs are precomputed from the next mask so they register cleanly.
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    mask_d  = mask_q;
    dst_d   = dst_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          words_d = words_in;
          mask_d  = mask_in;
          dst_d   = posReg;
          count_d = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (mask_q == '0) begin
          state_d = DONE;
        end else if (handshake) begin
          mask_d  = mask_q & (mask_q - NUM_DIRS'(1));
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == EMIT) && any_d;
    dir_d   = idx_d;
    move_d  = words_d[idx_d];
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  lowest_set_16 u_lowest (
    .req_i (mask_d),
    .idx_o (idx_d),
    .any_o (any_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      words_q <= '0;
      mask_q  <= '0;
      dst_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      dir_q   <= '0;
      move_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      mask_q  <= mask_d;
      dst_q   <= dst_d;
      count_q <= count_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      move_q  <= move_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_dir    = dir_q;
  assign out_dst    = dst_q;
  assign out_move   = move_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign move_count = count_q;

endmodule

// File: doc/move_collector.md
MOVE_COLLECTOR -- requirements
Module: move_collector

Interface
REQ-001 SHALL have parameter MOVE_W, default 11, meaning the width of a sliding or king move word.
REQ-002 SHALL have parameter KMOVE_W, default 8, meaning the width of a knight move word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port engineColor, input, 1 bit: the side to move; only moves of this color are emitted.
REQ-006 SHALL have port posReg, input, 6 bits: the square index of this cell; it is the destination of every collected move.
REQ-007 SHALL have ports U_move, D_move, L_move, R_move, UL_move, UR_move, DL_move, DR_move, each input, MOVE_W bits: the registered sliding and king moves arriving at this square.
REQ-008 SHALL have ports UUL_move, UUR_move, LLU_move, RRU_move, DDL_move, DDR_move, LLD_move, RRD_move, each input, KMOVE_W bits: the registered knight moves arriving at this square.
REQ-009 SHALL have port start, input, 1 bit: a single-cycle request to snapshot and collect.
REQ-010 SHALL have port out_valid, output, 1 bit: out_dir, out_dst and out_move hold a move.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the move when out_ready and out_valid are both high on an edge.
REQ-012 SHALL have port out_dir, output, 4 bits: the direction code of the move being offered.
REQ-013 SHALL have port out_dst, output, 6 bits: the latched posReg.
REQ-014 SHALL have port out_move, output, MOVE_W bits: the move word; knight words are zero-extended.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1 bit: a one-cycle pulse when collection ends.
REQ-017 SHALL have port move_count, output, 5 bits: the number of handshakes in the current or last collection.

Function
REQ-018 SHALL use direction codes 0-15 in this order: U, D, L, R, UL, UR, DL, DR, UUL, UUR, LLU, RRU, DDL, DDR, LLD, RRD.
REQ-019 SHALL implement exactly the states IDLE, EMIT and DONE.
REQ-020 SHALL, in IDLE when start=1, latch all 16 move words and posReg, clear move_count, build the pending mask, and go to EMIT.
REQ-021 SHALL set pending mask bit i when word i is nonzero and its color bit equals engineColor; the color bit is bit 10 for sliding words and bit 7 for knight words.
REQ-022 SHALL assert out_valid in EMIT whenever the pending mask is nonzero, presenting the lowest set index; gaps SHALL be skipped in zero cycles.
REQ-023 SHALL, on a handshake, clear that mask bit and increment move_count; the next move SHALL be offered the following cycle.
REQ-024 SHALL hold out_dir, out_dst and out_move stable while out_valid=1 and out_ready=0.
REQ-025 SHALL go from EMIT to DONE when the mask is zero, including an empty snapshot, which reaches DONE one cycle after start.
REQ-026 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE.
REQ-027 SHALL ignore start outside IDLE, with no effect on the latched data.
REQ-028 SHALL not follow changes on the move inputs after the snapshot; EMIT uses only latched data.
REQ-029 SHALL drive out_valid=0 outside EMIT.
REQ-030 SHALL keep move_count saturated-safe: at most 16, so 5 bits never wrap.

Reset
REQ-031 SHALL, while rst_n=0, immediately force: state IDLE; out_valid, busy and done 0; move_count 0; mask, latched words, out_dir, out_dst and out_move all 0.
REQ-032 SHALL abort a collection if reset is asserted mid-collection, with no done pulse.
REQ-033 SHALL accept start on the first edge after rst_n deasserts.

Structure
REQ-034 SHALL take from shared package chess_pkg: the direction code constants, MOVE_W and KMOVE_W, EMPTY_MOVE and EMPTY_KNIGHT_MOVE, the color-bit positions, and the state enum.
REQ-035 SHALL contain one sub-module, lowest_set_16: a combinational 16-bit priority encoder giving the lowest index plus an any flag.
REQ-036 SHALL fit in 120-400 lines of RTL.

Verification
REQ-037 SHALL cover: engineColor=0, U_move=11'h200, UUL_move=8'h05, rest 0, posReg=27, start with out_ready=1 -> out_dir=0 then out_dir=8 with out_move=11'h005, out_dst=27 both times, done two cycles after the last handshake edge window, move_count=2.
REQ-038 SHALL cover: engineColor=1, U_move=11'h200, DR_move=11'h500 -> only DR is emitted (out_dir=7, out_move=11'h500); move_count=1.
REQ-039 SHALL cover: all inputs zero, start -> out_valid stays 0, done one cycle after start, move_count=0.
REQ-040 SHALL cover: 3 valid moves with out_ready held low for 5 cycles -> first move held stable, no loss; then out_ready=1 gives 3 handshakes in 3 cycles.
REQ-041 SHALL cover: start during EMIT with changed inputs -> ignored; the original snapshot is completed.
REQ-042 SHALL cover: rst_n pulsed low mid-EMIT -> out_valid and busy go 0 asynchronously, no done; a new start then works normally.
